// File: rtl/west_feeder_pkg.sv
// Shared constants for the west-edge feeder: per-row instruction codes and
// controller state encoding.
package west_feeder_pkg;

   localparam logic [1:0] INST_IDLE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

endpackage

// File: rtl/west_feeder_if.sv
// Upstream side of the feeder: row-vector stream plus issue command handshake.
interface west_feeder_if #(
   parameter int bw     = 4,
   parameter int row    = 8,
   parameter int len_bw = 8
);
   logic [row*bw-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic [len_bw-1:0] cmd_len;
   logic              cmd_ready;

   modport master (
      output in_data, in_valid, cmd_valid, cmd_op, cmd_len,
      input  in_ready, cmd_ready
   );

   modport slave (
      input  in_data, in_valid, cmd_valid, cmd_op, cmd_len,
      output in_ready, cmd_ready
   );
endinterface

// File: rtl/vec_fifo.sv
// Synchronous row-vector FIFO with occupancy counter; pushes at full and pops
// at empty are ignored.
module vec_fifo #(
   parameter int width = 32,
   parameter int depth = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [width-1:0] wr_data,
   input  logic             pop,
   output logic [width-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(depth);

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == (AW+1)'(depth));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/west_feeder.sv
// West-edge driver of the systolic array: buffers row-vectors, issues them
// under command control, and skews row r by r cycles behind row 0.
module west_feeder
   import west_feeder_pkg::*;
#(
   parameter int bw         = 4,
   parameter int row        = 8,
   parameter int fifo_depth = 16,
   parameter int len_bw     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   west_feeder_if.slave      bus,
   output logic [row*bw-1:0] out_w,
   output logic [row*2-1:0]  inst_w_out,
   output logic              busy,
   output logic              done
);
   localparam int DW = (row > 1) ? $clog2(row) : 1;
   localparam logic [DW-1:0] DLAST = DW'(row - 2);

   state_t            state;
   logic [1:0]        op;
   logic [len_bw-1:0] len;
   logic [len_bw-1:0] cnt;
   logic [len_bw-1:0] cnt_nxt;
   logic [DW-1:0]     dcnt;

   logic [row*bw-1:0] fifo_rd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              cmd_fire;
   logic [row*bw-1:0] issue_data;
   logic [1:0]        issue_inst;

   vec_fifo #(.width(row*bw), .depth(fifo_depth)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (bus.in_valid),
      .wr_data (bus.in_data),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.in_ready  = ~fifo_full;
   assign bus.cmd_ready = (state == S_IDLE);
   assign busy          = (state != S_IDLE);
   assign cmd_fire      = bus.cmd_valid && bus.cmd_ready &&
                          (bus.cmd_op == INST_KLOAD || bus.cmd_op == INST_EXEC);
   assign pop           = (state == S_RUN) && !fifo_empty;
   assign cnt_nxt       = cnt + len_bw'(1);
   assign issue_data    = pop ? fifo_rd : '0;
   assign issue_inst    = pop ? op : INST_IDLE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         op    <= INST_IDLE;
         len   <= '0;
         cnt   <= '0;
         dcnt  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_fire) begin
                  op  <= bus.cmd_op;
                  len <= bus.cmd_len;
                  cnt <= '0;
                  if (bus.cmd_len == '0) done <= 1'b1;
                  else                   state <= S_RUN;
               end
            end
            S_RUN: begin
               if (pop) begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == len) begin
                     state <= S_DRAIN;
                     dcnt  <= '0;
                     // a single-row array has no further skew stages to wait for
                     if (row == 1) done <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // done is raised while the last vector sits in the final row stage;
               // the controller returns to idle one cycle later
               if (done)                state <= S_IDLE;
               else if (dcnt == DLAST)  done  <= 1'b1;
               else                     dcnt  <= dcnt + DW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar r = 0; r < row; r++) begin : g_row
      logic [bw+1:0] chain [r+1];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int unsigned i = 0; i <= r; i++) chain[i] <= '0;
         end else begin
            chain[0] <= {issue_inst, issue_data[r*bw +: bw]};
            for (int unsigned i = 1; i <= r; i++) chain[i] <= chain[i-1];
         end
      end

      assign out_w[r*bw +: bw]    = chain[r][bw-1:0];
      assign inst_w_out[r*2 +: 2] = chain[r][bw+1:bw];
   end
endmodule

// File: tb/tb_west_feeder.sv
// Self-checking bench for west_feeder: cycle-indexed issue-history model plus
// directed scenarios with hand-computed expectations.
module tb_west_feeder;
   localparam int BW = 4;
   localparam int ROW = 8;
   localparam int DEPTH = 16;
   localparam int LBW = 8;

   logic              clk;
   logic              reset_n;
   logic [ROW*BW-1:0] out_w;
   logic [ROW*2-1:0]  inst_w_out;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   bit en = 0;

   west_feeder_if #(.bw(BW), .row(ROW), .len_bw(LBW)) bus();

   west_feeder #(.bw(BW), .row(ROW), .fifo_depth(DEPTH), .len_bw(LBW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .out_w      (out_w),
      .inst_w_out (inst_w_out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mq[$];
   logic [31:0] hd [0:4095];
   logic [1:0]  hi [0:4095];
   int          cyc;
   int          done_at;
   int          busy_end;
   int          m_left;
   int          pre_sz;
   bit          m_busy;
   bit          m_running;
   bit          busy_pre;
   logic [1:0]  m_op;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         for (int i = 0; i < 4096; i++) begin
            hd[i] = '0;
            hi[i] = '0;
         end
         cyc = 0; done_at = -1; busy_end = -1; m_left = 0;
         m_busy = 0; m_running = 0; m_op = 0;
      end else begin
         cyc++;
         pre_sz   = mq.size();
         busy_pre = m_busy;
         hd[cyc]  = '0;
         hi[cyc]  = '0;
         if (m_running && pre_sz > 0) begin
            hd[cyc] = mq.pop_front();
            hi[cyc] = m_op;
            m_left--;
            if (m_left == 0) begin
               m_running = 0;
               done_at   = cyc + ROW - 1;
               busy_end  = cyc + ROW;
            end
         end
         if (bus.in_valid && pre_sz < DEPTH) mq.push_back(bus.in_data);
         if (!busy_pre && bus.cmd_valid && (bus.cmd_op == 2'b01 || bus.cmd_op == 2'b10)) begin
            if (bus.cmd_len == 0) done_at = cyc;
            else begin
               m_busy = 1; m_running = 1; m_left = int'(bus.cmd_len);
               m_op = bus.cmd_op; busy_end = -1;
            end
         end
         if (busy_pre && cyc == busy_end) m_busy = 0;
      end
   end

   logic [31:0] exp_out;
   logic [15:0] exp_inst;
   int          idx;

   always @(posedge clk) begin
      #2;
      if (reset_n && en) begin
         for (int r = 0; r < ROW; r++) begin
            idx = cyc - r;
            if (idx >= 1) begin
               exp_out[r*BW +: BW] = hd[idx][r*BW +: BW];
               exp_inst[r*2 +: 2]  = hi[idx];
            end else begin
               exp_out[r*BW +: BW] = '0;
               exp_inst[r*2 +: 2]  = '0;
            end
         end
         chk("m_out_w", out_w, exp_out);
         chk("m_inst_w", inst_w_out, exp_inst);
         chk("m_done", done, done_at == cyc);
         chk("m_busy", busy, m_busy);
         chk("m_cmd_ready", bus.cmd_ready, !m_busy);
         chk("m_in_ready", bus.in_ready, mq.size() < DEPTH);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] len);
      bus.cmd_valid = 1;
      bus.cmd_op    = op;
      bus.cmd_len   = len;
   endtask

   logic [31:0] v;
   bit          seen;

   initial begin
      reset_n = 1;
      bus.in_valid = 0; bus.in_data = '0;
      bus.cmd_valid = 0; bus.cmd_op = '0; bus.cmd_len = '0;

      // asynchronous reset, checked before any clock edge
      #3 reset_n = 0;
      #1;
      chk("rst_out_w", out_w, 0);
      chk("rst_inst", inst_w_out, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      step(); step();
      reset_n = 1; en = 1;
      step();

      // prefill 8 vectors (nibbles = k), kernel load len 8
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1;
         bus.in_data  = 32'(k) * 32'h1111_1111;
         step();
      end
      bus.in_valid = 0;
      cmd(2'b01, 8'd8);
      for (int s = 1; s <= 17; s++) begin
         step();
         if (s == 1) bus.cmd_valid = 0;
         if (s == 2) begin
            chk("kl_row0_first_d", out_w[3:0], 4'h0);
            chk("kl_row0_first_i", inst_w_out[1:0], 2'b01);
         end
         if (s == 9) begin
            chk("kl_row0_last_d", out_w[3:0], 4'h7);
            chk("kl_row0_last_i", inst_w_out[1:0], 2'b01);
         end
         if (s == 10) chk("kl_row0_bubble", inst_w_out[1:0], 2'b00);
         if (s == 16) begin
            chk("kl_row7_last_d", out_w[31:28], 4'h7);
            chk("kl_row7_last_i", inst_w_out[15:14], 2'b01);
            chk("kl_done", done, 1);
            chk("kl_busy_at_done", busy, 1);
         end
         if (s == 17) chk("kl_idle", busy, 0);
      end

      // execute len 4 with a trickling FIFO
      cmd(2'b10, 8'd4);
      for (int s = 1; s <= 17; s++) begin
         step();
         if (s == 1) bus.cmd_valid = 0;
         if (s == 1 || s == 3 || s == 5 || s == 7) begin
            bus.in_valid = 1;
            bus.in_data  = 32'h1234_5670 + 32'((s - 1) / 2);
         end else bus.in_valid = 0;
         if (s == 2) chk("ex_bubble_e1", inst_w_out[1:0], 2'b00);
         if (s == 3) begin
            chk("ex_row0_v0_i", inst_w_out[1:0], 2'b10);
            chk("ex_row0_v0_d", out_w[3:0], 4'h0);
         end
         if (s == 4) chk("ex_bubble_e3", inst_w_out[1:0], 2'b00);
         if (s == 15) chk("ex_no_early_done", done, 0);
         if (s == 16) begin
            chk("ex_done", done, 1);
            chk("ex_row7_v3_d", out_w[31:28], 4'h1);
            chk("ex_row7_v3_i", inst_w_out[15:14], 2'b10);
         end
         if (s == 17) chk("ex_idle", busy, 0);
      end

      // fill to full, 17th vector held until a pop frees a slot
      for (int i = 0; i < 16; i++) begin
         bus.in_valid = 1;
         bus.in_data  = 32'hC0DE_0000 + 32'(i);
         step();
      end
      chk("full_ready_low", bus.in_ready, 0);
      bus.in_data = 32'hC0DE_0010;
      step();
      chk("full_held", bus.in_ready, 0);
      cmd(2'b01, 8'd1);
      step();
      bus.cmd_valid = 0;
      chk("full_accept_cycle", bus.in_ready, 0);
      step();
      chk("full_after_pop", bus.in_ready, 1);
      step();
      chk("full_refilled", bus.in_ready, 0);
      bus.in_valid = 0;
      repeat (10) step();

      // zero-length command and an illegal opcode
      cmd(2'b10, 8'd0);
      step();
      bus.cmd_valid = 0;
      chk("len0_done", done, 1);
      chk("len0_cmd_ready", bus.cmd_ready, 1);
      chk("len0_busy", busy, 0);
      step();
      chk("len0_done_once", done, 0);
      cmd(2'b11, 8'd5);
      step();
      chk("op11_cmd_ready", bus.cmd_ready, 1);
      chk("op11_busy", busy, 0);
      bus.cmd_valid = 0;
      step();
      chk("op11_still_idle", busy, 0);
      chk("op11_no_done", done, 0);

      // reset while draining three vectors
      cmd(2'b10, 8'd3);
      for (int s = 1; s <= 5; s++) begin
         step();
         if (s == 1) bus.cmd_valid = 0;
      end
      chk("pre_rst_busy", busy, 1);
      reset_n = 0;
      #1;
      chk("drn_rst_out_w", out_w, 0);
      chk("drn_rst_inst", inst_w_out, 0);
      chk("drn_rst_busy", busy, 0);
      chk("drn_rst_done", done, 0);
      chk("drn_rst_in_ready", bus.in_ready, 1);
      step(); step();
      reset_n = 1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("drn_no_done", done, 0);
      end
      cmd(2'b10, 8'd1);
      step();
      bus.cmd_valid = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_empty", inst_w_out, 0);
      end
      bus.in_valid = 1;
      bus.in_data  = 32'hFEDC_BA98;
      step();
      bus.in_valid = 0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         if (done) seen = 1;
      end
      chk("post_rst_done_seen", seen, 1);
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/west_feeder.md
Name: west_feeder

Overview:
- Drives the west edge of the systolic MAC array.
- Buffers row-vectors of activations or weights from the L0/SRAM side in a small FIFO. Issues them to each array row with the standard per-row one-cycle skew.
- Generates the 2-bit per-row instruction code: bit1 = execute, bit0 = kernel load.
- Transmitting end of the tile's in_w/inst_w interface: row r of the array sees exactly what a tile's west neighbour would present.

Parameters:
- bw, 4, activation/weight width per row
- row, 8, number of array rows driven
- fifo_depth, 16, input FIFO depth in row-vectors (power of 2, >=2)
- len_bw, 8, width of the command length field

Ports:
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_data  input  row*bw  row-vector; row r at bits [r*bw +: bw]
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept; transfer on in_valid & in_ready
- cmd_valid  input  1  command present
- cmd_op  input  2  01 = kernel load, 10 = execute; other codes are ignored and never accepted
- cmd_len  input  len_bw  number of vectors to issue
- cmd_ready  output  1  high only in IDLE
- out_w  output  row*bw  per-row data to array column 0 in_w
- inst_w_out  output  row*2  per-row instruction to array column 0 inst_w
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the last issued vector has left the row-(row-1) skew stage

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, all skew registers 0. Resulting outputs: out_w=0, inst_w_out=0, in_ready=1, cmd_ready=1, busy=0, done=0.
- FIFO:
  - in_ready = !full. It is not pop-aware; at full, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push/pop when neither full nor empty keeps the count unchanged.
  - Pointers wrap modulo fifo_depth.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: a command with cmd_valid & cmd_ready and a legal op latches op and len.
    - len != 0: RUN next cycle, issue counter = 0.
    - len == 0: done pulses next cycle, state stays IDLE.
  - RUN, each cycle:
    - FIFO non-empty: pop one vector and issue it to the row-0 stage with inst = latched op; counter increments.
    - FIFO empty: issue a bubble (data 0, inst 00); counter holds.
    - When the issue that makes counter == len happens, go to DRAIN.
  - DRAIN: run row-1 further cycles. done asserts in the cycle the final vector's row-(row-1) slice is on the outputs. Return to IDLE the following cycle.
- Skew:
  - Row r output = row-0 issue stage delayed r cycles.
  - Row 0: one register after the pop, so latency from pop to row-0 output is 1 cycle and to row r is 1+r cycles.
  - Data and inst travel together through identical delay chains.
  - The skew chain shifts every cycle in every state. IDLE injects bubbles.
- in_data may be pushed in any state, including IDLE; the FIFO prefills.
- Reset mid-RUN/DRAIN: immediate return to the reset values above. In-flight vectors are lost and no done pulse is produced.
- Ordering: vectors are issued in FIFO order. Reverse ordering for kernel load (the tile's load_ready latch keeps the first weight each tile sees) is software's responsibility.
- No arithmetic beyond the counter (len_bw bits, never wraps because it stops at len) and the FIFO pointers.

Decomposition:
- Package west_feeder_pkg holds:
  - INST_IDLE = 2'b00, INST_KLOAD = 2'b01, INST_EXEC = 2'b10
  - FSM state encoding (S_IDLE, S_RUN, S_DRAIN)
- One sub-module: vec_fifo (synchronous FIFO, width row*bw, depth fifo_depth, async active-low reset, full/empty flags).
- Skew chains live in the top level as a generate loop.

Test Plan (row=8, bw=4, fifo_depth=16):
- Reset with reset_n low mid-cycle, then release -> all outputs 0, in_ready=1, cmd_ready=1 immediately, without waiting for a clock edge.
- Prefill 8 vectors where vector k has every nibble = k, then cmd op=01 len=8:
  - row 0 shows nibble 0..7 with inst 01 on cycles 2..9 after command acceptance
  - row 7 shows the same values 7 cycles later
  - done pulses once, with busy high throughout.
- Cmd op=10 len=4 with an empty FIFO; push one vector every other cycle -> row 0 alternates data/bubble (inst 10/00), done only after the 4th vector exits row 7.
- Push 17 vectors back-to-back with no command -> in_ready drops after the 16th accept, the 17th is held; a later pop re-raises in_ready the next cycle.
- cmd op=10 len=0 -> done one cycle later, no non-zero inst_w_out ever, cmd_ready stays 1; cmd_op=11 -> not accepted, cmd_ready stays 1, no state change.
- Assert reset_n low during DRAIN with 3 vectors in the skew chain -> outputs zero asynchronously, no done pulse, the FIFO reads as empty afterwards.
